rtc_ir_rx: RTL and testbench
============================

// Module: rtc_ir_rx
// PURPOSE
//  Serial IR time-frame receiver that consumes the ir_o stream emitted by rtc_top.
//  Oversamples the line, deserializes one frame into the seven calendar fields and flags errors.
//  Presents the decoded time as held outputs with a one-cycle valid strobe.
//  Sits downstream of rtc_top, on the receiving node; it can also be looped back to ir_i.
// PARAMETERS
//  BIT_CYCLES  16  clk_i cycles per IR bit; must be >=4 and even.
// PORTS
//  clk_i    in   1   single clock; all logic on posedge
//  rst_i    in   1   synchronous, active-high reset
//  ir_i     in   1   serial IR line, asynchronous; idle low
//  sec_o    out  6   seconds, 0..59
//  min_o    out  6   minutes, 0..59
//  hours_o  out  8   [7]=12h mode, [6]=PM, [5:0]=hour
//  dow_o    out  3   day of week, 1..7
//  dom_o    out  5   day of month, 1..31
//  month_o  out  4   month, 1..12
//  year_o   out  12  year
//  valid_o  out  1   1-cycle pulse: a good frame was latched into the field outputs
//  err_o    out  1   1-cycle pulse: frame rejected (framing, parity or range error)
//  busy_o   out  1   high while a frame is in progress
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in IDLE; bit and sample counters 0.
//  - ir_i passes through a 2-FF synchronizer; all decisions use the synced value (2-cycle latency).
//  - Frame: start(1), then 44 data bits LSB-first, then parity (if enabled), then stop(0).
//  - Data order: sec6 min6 hours8 dow3 dom5 month4 year12.
//  - IDLE: a synced rising edge -> START; busy_o=1 from the next cycle.
//  - START: wait BIT_CYCLES/2 and resample. If still 1 -> DATA, otherwise glitch -> IDLE (no err).
//  - DATA: sample every BIT_CYCLES at bit centre; shift into a 44-bit shift register.
//    After the 44th bit -> PARITY, or -> STOP when parity is disabled.
//  - PARITY: sample; even parity over the 44 data bits plus the parity bit is required.
//  - STOP: sample; a value of 1 is a framing error.
//  - Range check: sec>59, min>59, hours[5:0]>23 (24h) or not in 1..12 (12h),
//    dow∉1..7, dom∉1..31, month∉1..12 -> error.
//  - STOP sample, no error: field outputs update and valid_o pulses in the same cycle;
//    then -> IDLE, busy_o=0 next cycle.
//  - STOP sample, any error: err_o pulses; field outputs keep the previous good frame; -> IDLE.
//  - valid_o and err_o are never high together.
//  - Rising edges during a frame are ignored (no resync).
//  - A new start is accepted the cycle after returning to IDLE; the line must fall low first
//    (edge detect).
//  - rst_i mid-frame: abort immediately, all outputs to reset values, no err_o.
//  - Counters saturate-free: the sample counter is $clog2(BIT_CYCLES) bits, the bit counter 6 bits.
// CONFIGURATION
//  RTC_IR_RX_PARITY_EN defined: the frame carries a parity bit (47 bits incl. start/stop),
//    and a parity mismatch raises err_o.
//  Not defined: no parity bit (46 bits); DATA goes straight to STOP; framing and range errors only.
// STRUCTURE
//  rtc_ir_pkg: field width localparams, DATA_BITS=44, state enum
//    (IDLE, START, DATA, PARITY, STOP), and the packed struct rtc_time_t for the seven fields.
//    The pkg is shared with the future rtc_ir_tx.
//  Sub-module rtc_ir_bit_timer: sample counter producing mid_tick/bit_tick; cleared on state entry.
//  Top holds the synchronizer, FSM, shift register, parity accumulator and range checker.
// TESTING
//  1. 59s 59m 23h dow7 dom31 month12 year2000, good parity
//     -> valid_o once ~46*BIT_CYCLES after start; fields exact.
//  2. 1-cycle high glitch on ir_i while idle -> no valid_o/err_o, busy_o returns to 0.
//  3. Frame with stop bit=1 -> err_o pulse; outputs retain the previous frame from test 1.
//  4. Flipped data bit, RTC_IR_RX_PARITY_EN set -> err_o;
//     same frame built without the macro -> valid_o.
//  5. Range errors: month=13 -> err_o; hours=8'b11_001011 (PM 11h) -> valid_o, hours_o=0xCB.
//  6. rst_i asserted mid-DATA -> all outputs 0 next cycle; the following good frame decodes correctly.

Source files
------------

// File: rtl/rtc_ir_pkg.sv
// Shared definitions for the RTC IR time-frame link (receiver now, transmitter later).
// Field widths, frame data length, receiver state encoding and the packed calendar record.
package rtc_ir_pkg;

   localparam int SEC_W     = 6;
   localparam int MIN_W     = 6;
   localparam int HOURS_W   = 8;
   localparam int DOW_W     = 3;
   localparam int DOM_W     = 5;
   localparam int MONTH_W   = 4;
   localparam int YEAR_W    = 12;
   localparam int DATA_BITS = 44;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   // sec occupies the LSBs so a LSB-first shift register maps straight onto this record
   typedef struct packed {
      logic [YEAR_W-1:0]  year;
      logic [MONTH_W-1:0] month;
      logic [DOM_W-1:0]   dom;
      logic [DOW_W-1:0]   dow;
      logic [HOURS_W-1:0] hours;
      logic [MIN_W-1:0]   min;
      logic [SEC_W-1:0]   sec;
   } rtc_time_t;

endpackage

// File: rtl/rtc_ir_bit_timer.sv
// Per-bit sample counter for the IR receiver: mid_tick half a bit after clear,
// bit_tick every full bit period after clear.
module rtc_ir_bit_timer #(
   parameter int BIT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic mid_tick,
   output logic bit_tick
);

   localparam int CW = $clog2(BIT_CYCLES);

   logic [CW-1:0] cnt;

   assign mid_tick = (cnt == CW'(BIT_CYCLES / 2 - 1));
   assign bit_tick = (cnt == CW'(BIT_CYCLES - 1));

   // explicit wrap keeps non-power-of-two bit periods exact
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (bit_tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/rtc_ir_rx.sv
// Serial IR calendar-frame receiver: synchronizer, frame FSM, deserializer and checker.
// Optional parity bit enabled with the RTC_IR_RX_PARITY_EN macro.
module rtc_ir_rx
   import rtc_ir_pkg::*;
#(
   parameter int BIT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ir_i,
   output logic [5:0]  sec_o,
   output logic [5:0]  min_o,
   output logic [7:0]  hours_o,
   output logic [2:0]  dow_o,
   output logic [4:0]  dom_o,
   output logic [3:0]  month_o,
   output logic [11:0] year_o,
   output logic        valid_o,
   output logic        err_o,
   output logic        busy_o
);

   state_t                 state, state_next;
   logic                   ir_p0, ir_p1, ir_p2;
   logic                   rise;
   logic                   timer_clr, mid_tick, bit_tick;
   logic                   shift_en, frame_done, bad_parity;
   logic [5:0]             bit_cnt;
   logic [DATA_BITS-1:0]   shreg;
   rtc_time_t              fields;

   function automatic logic fields_in_range(input rtc_time_t t);
      logic [5:0] h;
      logic       hour_ok;
      h = t.hours[5:0];
      hour_ok = t.hours[7] ? (h >= 6'd1 && h <= 6'd12) : (h <= 6'd23);
      return (t.sec <= 6'd59) && (t.min <= 6'd59) && hour_ok &&
             (t.dow != 3'd0) && (t.dom != 5'd0) &&
             (t.month >= 4'd1) && (t.month <= 4'd12);
   endfunction

   // stage p0/p1: metastability synchronizer, p2: previous value for edge detect
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ir_p0 <= 1'b0;
         ir_p1 <= 1'b0;
         ir_p2 <= 1'b0;
      end else begin
         ir_p0 <= ir_i;
         ir_p1 <= ir_p0;
         ir_p2 <= ir_p1;
      end
   end

   assign rise      = ir_p1 & ~ir_p2;
   assign timer_clr = (state == IDLE) || (state_next != state);
   assign busy_o    = (state != IDLE);

   rtc_ir_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
      .clk      (clk_i),
      .rst      (rst_i),
      .clr      (timer_clr),
      .mid_tick (mid_tick),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      shift_en   = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE:  if (rise) state_next = START;
         START: if (mid_tick) state_next = ir_p1 ? DATA : IDLE;
         DATA: begin
            if (bit_tick) begin
               shift_en = 1'b1;
               if (bit_cnt == 6'(DATA_BITS - 1)) begin
`ifdef RTC_IR_RX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef RTC_IR_RX_PARITY_EN
         PARITY: if (bit_tick) state_next = STOP;
`endif
         STOP: begin
            if (bit_tick) begin
               frame_done = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // stage p3: deserializer, data only
   always_ff @(posedge clk_i) begin
      if (shift_en) shreg <= {ir_p1, shreg[DATA_BITS-1:1]};
   end

`ifdef RTC_IR_RX_PARITY_EN
   logic par_acc;

   always_ff @(posedge clk_i) begin
      if (rst_i || state == START) begin
         par_acc <= 1'b0;
      end else if (shift_en || (state == PARITY && bit_tick)) begin
         par_acc <= par_acc ^ ir_p1;
      end
   end

   assign bad_parity = par_acc;
`else
   assign bad_parity = 1'b0;
`endif

   // stage p4: frame decision and held field outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bit_cnt <= '0;
         fields  <= '0;
         valid_o <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         err_o   <= 1'b0;
         if (state == START) bit_cnt <= '0;
         else if (shift_en)  bit_cnt <= bit_cnt + 1'b1;
         if (frame_done) begin
            if (ir_p1 || bad_parity || !fields_in_range(rtc_time_t'(shreg))) begin
               err_o <= 1'b1;
            end else begin
               fields  <= rtc_time_t'(shreg);
               valid_o <= 1'b1;
            end
         end
      end
   end

   assign sec_o   = fields.sec;
   assign min_o   = fields.min;
   assign hours_o = fields.hours;
   assign dow_o   = fields.dow;
   assign dom_o   = fields.dom;
   assign month_o = fields.month;
   assign year_o  = fields.year;

endmodule

// File: tb/tb_rtc_ir_rx.sv
// Directed self-checking bench for rtc_ir_rx (default BIT_CYCLES=16).
// Honours RTC_IR_RX_PARITY_EN so the same bench drives either frame format.
module tb_rtc_ir_rx;

   localparam int BC = 16;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        ir_i;
   logic [5:0]  sec_o, min_o;
   logic [7:0]  hours_o;
   logic [2:0]  dow_o;
   logic [4:0]  dom_o;
   logic [3:0]  month_o;
   logic [11:0] year_o;
   logic        valid_o, err_o, busy_o;

   int cyc = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int last_valid_cyc = 0;
   int t_start = 0;
   int checks = 0;
   int errors = 0;
   int v0, e0;

   rtc_ir_rx #(.BIT_CYCLES(BC)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .ir_i    (ir_i),
      .sec_o   (sec_o),
      .min_o   (min_o),
      .hours_o (hours_o),
      .dow_o   (dow_o),
      .dom_o   (dom_o),
      .month_o (month_o),
      .year_o  (year_o),
      .valid_o (valid_o),
      .err_o   (err_o),
      .busy_o  (busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_o) begin
         valid_cnt      <= valid_cnt + 1;
         last_valid_cyc <= cyc;
      end
      if (err_o) err_cnt <= err_cnt + 1;
      if (valid_o && err_o) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [43:0] mk(input int s, input int m, input int h, input int dw,
                                      input int dm, input int mo, input int y);
      return {y[11:0], mo[3:0], dm[4:0], dw[2:0], h[7:0], m[5:0], s[5:0]};
   endfunction

   task automatic drive_bit(input logic b);
      @(negedge clk);
      ir_i = b;
      repeat (BC - 1) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // parity is computed over the intended data; flip corrupts the bits actually sent
   task automatic send_frame(input logic [43:0] d, input logic [43:0] flip, input logic stop_v);
      logic [43:0] tx;
      tx = d ^ flip;
      @(negedge clk);
      t_start = cyc;
      ir_i = 1'b1;
      repeat (BC - 1) @(negedge clk);
      for (int i = 0; i < 44; i++) drive_bit(tx[i]);
`ifdef RTC_IR_RX_PARITY_EN
      drive_bit(^d);
`endif
      drive_bit(stop_v);
      @(negedge clk);
      ir_i = 1'b0;
   endtask

   task automatic check_fields(input string tag, input logic [43:0] d);
      check({tag, ".sec"},   32'(sec_o),   32'(d[5:0]));
      check({tag, ".min"},   32'(min_o),   32'(d[11:6]));
      check({tag, ".hours"}, 32'(hours_o), 32'(d[19:12]));
      check({tag, ".dow"},   32'(dow_o),   32'(d[22:20]));
      check({tag, ".dom"},   32'(dom_o),   32'(d[27:23]));
      check({tag, ".month"}, 32'(month_o), 32'(d[31:28]));
      check({tag, ".year"},  32'(year_o),  32'(d[43:32]));
   endtask

   initial begin
      logic [43:0] f1, f3, f4, f4x, f5a, f5b, f6;
      int lat;
      f1  = mk(59, 59, 23, 7, 31, 12, 2000);
      f3  = mk(1, 2, 3, 4, 5, 6, 7);
      f4  = mk(10, 20, 5, 3, 15, 6, 2024);
      f4x = mk(10, 20, 5, 3, 15, 6, 2025);
      f5a = mk(0, 0, 0, 1, 1, 13, 2001);
      f5b = mk(30, 45, 8'hCB, 2, 28, 2, 1999);
      f6  = mk(7, 8, 8'h81, 5, 9, 10, 123);

      rst_i = 1'b1;
      ir_i  = 1'b0;
      idle(4);
      rst_i = 1'b0;
      idle(2);
      check("rst.fields", {sec_o, min_o, hours_o, dow_o, dom_o, month_o}, 32'h0);
      check("rst.year", 32'(year_o), 32'h0);
      check("rst.flags", {29'h0, valid_o, err_o, busy_o}, 32'h0);

      // 1: maximum-value good frame
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(f1, 44'h0, 1'b0);
      idle(2 * BC);
      check("t1.valid_cnt", 32'(valid_cnt - v0), 32'd1);
      check("t1.err_cnt", 32'(err_cnt - e0), 32'd0);
      lat = last_valid_cyc - t_start;
      check("t1.latency_window", 32'((lat >= 44 * BC) && (lat <= 48 * BC)), 32'd1);
      check_fields("t1", f1);
      check("t1.busy", 32'(busy_o), 32'd0);

      // 2: single-cycle glitch while idle
      v0 = valid_cnt; e0 = err_cnt;
      @(negedge clk); ir_i = 1'b1;
      @(negedge clk); ir_i = 1'b0;
      idle(3);
      check("t2.busy_during", 32'(busy_o), 32'd1);
      idle(2 * BC);
      check("t2.valid_cnt", 32'(valid_cnt - v0), 32'd0);
      check("t2.err_cnt", 32'(err_cnt - e0), 32'd0);
      check("t2.busy_after", 32'(busy_o), 32'd0);

      // 3: framing error keeps the previous frame
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(f3, 44'h0, 1'b1);
      idle(2 * BC);
      check("t3.err_cnt", 32'(err_cnt - e0), 32'd1);
      check("t3.valid_cnt", 32'(valid_cnt - v0), 32'd0);
      check_fields("t3", f1);

      // 4: one flipped data bit (year LSB)
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(f4, 44'h1 << 32, 1'b0);
      idle(2 * BC);
`ifdef RTC_IR_RX_PARITY_EN
      check("t4.err_cnt", 32'(err_cnt - e0), 32'd1);
      check("t4.valid_cnt", 32'(valid_cnt - v0), 32'd0);
      check_fields("t4", f1);
`else
      check("t4.err_cnt", 32'(err_cnt - e0), 32'd0);
      check("t4.valid_cnt", 32'(valid_cnt - v0), 32'd1);
      check_fields("t4", f4x);
`endif

      // 5a: month out of range
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(f5a, 44'h0, 1'b0);
      idle(2 * BC);
      check("t5a.err_cnt", 32'(err_cnt - e0), 32'd1);
      check("t5a.valid_cnt", 32'(valid_cnt - v0), 32'd0);

      // 5b: 12h mode, PM, 11 o'clock
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(f5b, 44'h0, 1'b0);
      idle(2 * BC);
      check("t5b.valid_cnt", 32'(valid_cnt - v0), 32'd1);
      check("t5b.err_cnt", 32'(err_cnt - e0), 32'd0);
      check("t5b.hours", 32'(hours_o), 32'hCB);
      check_fields("t5b", f5b);

      // 6: reset in the middle of the data bits
      v0 = valid_cnt; e0 = err_cnt;
      drive_bit(1'b1);
      for (int i = 0; i < 10; i++) drive_bit(f6[i]);
      check("t6.busy_mid", 32'(busy_o), 32'd1);
      @(negedge clk);
      rst_i = 1'b1;
      ir_i  = 1'b0;
      @(negedge clk);
      check("t6.rst_fields", {sec_o, min_o, hours_o, dow_o, dom_o, month_o}, 32'h0);
      check("t6.rst_year", 32'(year_o), 32'h0);
      check("t6.rst_flags", {29'h0, valid_o, err_o, busy_o}, 32'h0);
      rst_i = 1'b0;
      idle(4 * BC);
      check("t6.no_err", 32'(err_cnt - e0), 32'd0);
      send_frame(f6, 44'h0, 1'b0);
      idle(2 * BC);
      check("t6.valid_cnt", 32'(valid_cnt - v0), 32'd1);
      check_fields("t6", f6);

      check("never_both", 32'(both_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
